// File: rtl/rtc_pkg.sv
// Shared time-of-day types, field limits and helper arithmetic for the RTC core.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rtc_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [HOUR_W-1:0] HOUR_NOON = 5'd12;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } rtc_time_t;

    localparam rtc_time_t TIME_ZERO = '0;

    // 24 h hour to 12 h display hour: midnight shows as 12, afternoon folds down by 12.
    function automatic logic [HOUR_W-1:0] to12h(input logic [HOUR_W-1:0] h);
        logic [HOUR_W-1:0] r;
        if (h == 5'd0) begin
            r = HOUR_NOON;
        end else if (h > HOUR_NOON) begin
            r = h - HOUR_NOON;
        end else begin
            r = h;
        end
        return r;
    endfunction

    // Range check shared by time load and alarm write.
    function automatic logic time_valid(input logic [HOUR_W-1:0] h,
                                        input logic [MIN_W-1:0]  m,
                                        input logic [SEC_W-1:0]  s);
        return (h <= HOUR_MAX) && (m <= MIN_MAX) && (s <= SEC_MAX);
    endfunction

    // One second forward with carries; 23:59:59 wraps to 00:00:00.
    function automatic rtc_time_t time_inc(input rtc_time_t t);
        rtc_time_t r;
        r = t;
        if (t.sec == SEC_MAX) begin
            r.sec = '0;
            if (t.min == MIN_MAX) begin
                r.min  = '0;
                r.hour = (t.hour == HOUR_MAX) ? '0 : t.hour + 5'd1;
            end else begin
                r.min = t.min + 6'd1;
            end
        end else begin
            r.sec = t.sec + 6'd1;
        end
        return r;
    endfunction

    // One second backward with borrows; 00:00:00 would wrap to 23:59:59,
    // but the timekeeper never applies a decrement at zero.
    function automatic rtc_time_t time_dec(input rtc_time_t t);
        rtc_time_t r;
        r = t;
        if (t.sec == '0) begin
            r.sec = SEC_MAX;
            if (t.min == '0) begin
                r.min  = MIN_MAX;
                r.hour = (t.hour == '0) ? HOUR_MAX : t.hour - 5'd1;
            end else begin
                r.min = t.min - 6'd1;
            end
        end else begin
            r.sec = t.sec - 6'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// One-second tick source: internal prescaler or falling edge of an external 1 Hz wave.
// Latency: internal tick combinational from the prescaler; external tick one cycle after the edge.
// Backpressure: none; tick is a free-running single-cycle strobe.
module rtc_tick_gen
    import rtc_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter bit USE_EXT_TICK = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    input  logic presc_clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] presc_q;
    logic          tick_in_d;

    // Prescaler wraps at TICK_DIV-1; restart requests realign it so the next second is full length.
    // In external-tick mode it is parked at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (USE_EXT_TICK || presc_clr || (presc_q == LAST)) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + ONE;
        end
    end

    // Delay flop for external falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_in_d <= 1'b0;
        end else begin
            tick_in_d <= tick_in;
        end
    end

    assign tick = USE_EXT_TICK ? (tick_in_d & ~tick_in) : (presc_q == LAST);

endmodule

// File: rtl/rtc_timekeeper.sv
// hh:mm:ss up/down counter with load, clear, run control, 12/24 h view and hh:mm alarm.
// Latency: time, running and all strobes register one cycle after the tick/command; view is combinational.
// Backpressure: none; commands are single-cycle pulses, out-of-range writes are dropped with load_err.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter bit USE_EXT_TICK = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic              btn_start,
    input  logic              btn_pause,
    input  logic              btn_clear,
    input  logic              count_down,
    input  logic              mode_12h,
    input  logic              load,
    input  logic [HOUR_W-1:0] ld_hour,
    input  logic [MIN_W-1:0]  ld_min,
    input  logic [SEC_W-1:0]  ld_sec,
    input  logic              alarm_wr,
    input  logic [HOUR_W-1:0] al_hour,
    input  logic [MIN_W-1:0]  al_min,
    input  logic              alarm_en,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [HOUR_W-1:0] disp_hour,
    output logic              pm,
    output logic              running,
    output logic              sec_pulse,
    output logic              alarm_hit,
    output logic              timer_done,
    output logic              load_err
);

    rtc_time_t         cur_q;
    rtc_time_t         ld_time;
    rtc_time_t         up_time;
    rtc_time_t         dn_time;
    rtc_time_t         alarm_time;
    logic [HOUR_W-1:0] al_hour_q;
    logic [MIN_W-1:0]  al_min_q;
    logic              running_q;
    logic              sec_pulse_q;
    logic              alarm_hit_q;
    logic              timer_done_q;
    logic              load_err_q;

    logic tick;
    logic ld_ok;
    logic al_ok;
    logic presc_clr;
    logic step_en;
    logic step_up;
    logic step_dn;
    logic at_zero;
    logic dn_apply;
    logic cd_end;

    rtc_tick_gen #(
        .TICK_DIV     (TICK_DIV),
        .USE_EXT_TICK (USE_EXT_TICK)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .presc_clr (presc_clr),
        .tick      (tick)
    );

    assign ld_ok      = time_valid(ld_hour, ld_min, ld_sec);
    assign al_ok      = time_valid(al_hour, al_min, 6'd0);
    assign ld_time    = {ld_hour, ld_min, ld_sec};
    assign alarm_time = {al_hour_q, al_min_q, 6'd0};

    // Restart the second on clear, accepted load, or a start from the stopped state.
    assign presc_clr = btn_clear | (load & ld_ok) | (btn_start & ~running_q);

    // Clear and load (even a rejected one) own the cycle; a coincident tick is dropped.
    assign step_en  = tick & running_q & ~btn_clear & ~load;
    assign step_up  = step_en & ~count_down;
    assign step_dn  = step_en & count_down;
    assign at_zero  = (cur_q == TIME_ZERO);
    assign up_time  = time_inc(cur_q);
    assign dn_time  = time_dec(cur_q);

    // A countdown tick either lands on zero or is already at zero (no wrap); both end the timer.
    assign dn_apply = step_dn & ~at_zero;
    assign cd_end   = step_dn & (at_zero | (dn_time == TIME_ZERO));

    // Time register: clear > load > tick step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q <= TIME_ZERO;
        end else if (btn_clear) begin
            cur_q <= TIME_ZERO;
        end else if (load) begin
            if (ld_ok) begin
                cur_q <= ld_time;
            end
        end else if (step_up) begin
            cur_q <= up_time;
        end else if (dn_apply) begin
            cur_q <= dn_time;
        end
    end

    // Run state: pause beats start, and reaching the end of a countdown stops the timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_q <= 1'b0;
        end else if (cd_end || btn_pause) begin
            running_q <= 1'b0;
        end else if (btn_start) begin
            running_q <= 1'b1;
        end
    end

    // Stored alarm hh:mm, only replaced by an in-range write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            al_hour_q <= '0;
            al_min_q  <= '0;
        end else if (alarm_wr && al_ok) begin
            al_hour_q <= al_hour;
            al_min_q  <= al_min;
        end
    end

    // Single-cycle strobes, registered alongside the time they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_pulse_q  <= 1'b0;
            alarm_hit_q  <= 1'b0;
            timer_done_q <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            sec_pulse_q  <= step_up | dn_apply;
            alarm_hit_q  <= step_up & alarm_en & (up_time == alarm_time);
            timer_done_q <= cd_end;
            load_err_q   <= (load & ~ld_ok) | (alarm_wr & ~al_ok);
        end
    end

    assign sec        = cur_q.sec;
    assign min        = cur_q.min;
    assign hour       = cur_q.hour;
    assign disp_hour  = mode_12h ? to12h(cur_q.hour) : cur_q.hour;
    assign pm         = (cur_q.hour >= HOUR_NOON);
    assign running    = running_q;
    assign sec_pulse  = sec_pulse_q;
    assign alarm_hit  = alarm_hit_q;
    assign timer_done = timer_done_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper with a seconds-of-day reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rtc_timekeeper;

    localparam int TD  = 4;
    localparam int DAY = 86400;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_in, btn_start, btn_pause, btn_clear, count_down, mode_12h;
    logic       load, alarm_wr, alarm_en;
    logic [4:0] ld_hour, al_hour;
    logic [5:0] ld_min, ld_sec, al_min;
    logic [5:0] sec, min;
    logic [4:0] hour, disp_hour;
    logic       pm, running, sec_pulse, alarm_hit, timer_done, load_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: time as seconds of the day, alarm as seconds of the day.
    int m_t, m_al, m_pc;
    bit m_run, e_pulse, e_hit, e_done, e_err;

    always #5 clk = ~clk;

    rtc_timekeeper #(.TICK_DIV(TD), .USE_EXT_TICK(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .btn_start  (btn_start),
        .btn_pause  (btn_pause),
        .btn_clear  (btn_clear),
        .count_down (count_down),
        .mode_12h   (mode_12h),
        .load       (load),
        .ld_hour    (ld_hour),
        .ld_min     (ld_min),
        .ld_sec     (ld_sec),
        .alarm_wr   (alarm_wr),
        .al_hour    (al_hour),
        .al_min     (al_min),
        .alarm_en   (alarm_en),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .disp_hour  (disp_hour),
        .pm         (pm),
        .running    (running),
        .sec_pulse  (sec_pulse),
        .alarm_hit  (alarm_hit),
        .timer_done (timer_done),
        .load_err   (load_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int exp_disp(input int h, input bit m12);
        if (!m12)   return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    task automatic model_reset();
        m_t = 0; m_al = 0; m_pc = 0; m_run = 1'b0;
        e_pulse = 1'b0; e_hit = 1'b0; e_done = 1'b0; e_err = 1'b0;
    endtask

    task automatic check_outputs();
        int h;
        h = m_t / 3600;
        chk("hour", hour, h);
        chk("min", min, (m_t / 60) % 60);
        chk("sec", sec, m_t % 60);
        chk("running", running, m_run);
        chk("sec_pulse", sec_pulse, e_pulse);
        chk("alarm_hit", alarm_hit, e_hit);
        chk("timer_done", timer_done, e_done);
        chk("load_err", load_err, e_err);
        chk("disp_hour", disp_hour, exp_disp(h, mode_12h));
        chk("pm", pm, (h >= 12) ? 1 : 0);
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT and compare.
    task automatic cycle();
        bit tick, ld_ok, al_ok, nrun, pclr;
        tick  = (m_pc == TD - 1);
        ld_ok = (ld_hour <= 23) && (ld_min <= 59) && (ld_sec <= 59);
        al_ok = (al_hour <= 23) && (al_min <= 59);
        e_pulse = 1'b0; e_hit = 1'b0; e_done = 1'b0;
        e_err = (load && !ld_ok) || (alarm_wr && !al_ok);
        nrun  = btn_pause ? 1'b0 : (btn_start ? 1'b1 : m_run);
        pclr  = btn_clear || (load && ld_ok) || (btn_start && !m_run);
        if (btn_clear) begin
            m_t = 0;
        end else if (load) begin
            if (ld_ok) m_t = ld_hour * 3600 + ld_min * 60 + ld_sec;
        end else if (tick && m_run) begin
            if (!count_down) begin
                m_t = (m_t + 1) % DAY;
                e_pulse = 1'b1;
                e_hit = alarm_en && (m_t == m_al);
            end else if (m_t == 0) begin
                nrun = 1'b0; e_done = 1'b1;
            end else begin
                m_t = m_t - 1;
                e_pulse = 1'b1;
                if (m_t == 0) begin
                    nrun = 1'b0; e_done = 1'b1;
                end
            end
        end
        if (alarm_wr && al_ok) m_al = al_hour * 3600 + al_min * 60;
        m_pc  = pclr ? 0 : (m_pc + 1) % TD;
        m_run = nrun;
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic load_time(input int h, input int m, input int s);
        ld_hour = 5'(h); ld_min = 6'(m); ld_sec = 6'(s);
        load = 1'b1; cycle(); load = 1'b0;
    endtask

    task automatic do_start();
        btn_start = 1'b1; cycle(); btn_start = 1'b0;
    endtask

    task automatic do_pause();
        btn_pause = 1'b1; cycle(); btn_pause = 1'b0;
    endtask

    task automatic expect_time(input string tag, input int h, input int m, input int s);
        chk(tag, {15'd0, hour, min, sec}, (h << 12) | (m << 6) | s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hits;
        int hrs [4] = '{0, 12, 13, 23};
        int dhr [4] = '{12, 12, 1, 11};
        int pmv [4] = '{0, 1, 1, 1};

        rst = 1'b1; tick_in = 1'b0; btn_start = 1'b0; btn_pause = 1'b0; btn_clear = 1'b0;
        count_down = 1'b0; mode_12h = 1'b0; load = 1'b0; alarm_wr = 1'b0; alarm_en = 1'b0;
        ld_hour = '0; ld_min = '0; ld_sec = '0; al_hour = '0; al_min = '0;
        model_reset();
        #12;
        check_outputs();
        rst = 1'b0;

        // Count up four seconds from a fresh start.
        do_start();
        run(16);
        expect_time("up_4s", 0, 0, 4);

        // Midnight rollover, then an out-of-range load.
        load_time(23, 59, 58);
        run(4);
        expect_time("roll_a", 23, 59, 59);
        run(4);
        expect_time("roll_b", 0, 0, 0);
        load_time(24, 0, 0);
        chk("ld24_err", load_err, 1);
        expect_time("ld24_keep", 0, 0, 0);

        // Countdown to zero, then a tick while parked at zero.
        do_pause();
        count_down = 1'b1;
        load_time(0, 0, 2);
        do_start();
        run(4);
        expect_time("cd_1", 0, 0, 1);
        run(4);
        chk("cd_done", timer_done, 1);
        chk("cd_stop", running, 0);
        expect_time("cd_0", 0, 0, 0);
        do_start();
        run(4);
        chk("cd_done_again", timer_done, 1);
        chk("cd_stop_again", running, 0);
        expect_time("cd_no_wrap", 0, 0, 0);

        // Borrow chains.
        load_time(0, 59, 59);
        do_start();
        run(4);
        expect_time("borrow_sec", 0, 59, 58);
        do_pause();
        load_time(1, 0, 0);
        do_start();
        run(4);
        expect_time("borrow_hour", 0, 59, 59);
        do_pause();

        // Alarm fires exactly once on the up-count.
        count_down = 1'b0;
        alarm_en = 1'b1;
        al_hour = 5'd7; al_min = 6'd30;
        alarm_wr = 1'b1; cycle(); alarm_wr = 1'b0;
        load_time(7, 29, 59);
        do_start();
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (alarm_hit) hits++;
        end
        chk("alarm_once", hits, 1);
        do_pause();

        // No alarm on the way down through 07:30:00.
        count_down = 1'b1;
        load_time(7, 30, 1);
        do_start();
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (alarm_hit) hits++;
        end
        chk("alarm_none_down", hits, 0);
        expect_time("down_past_alarm", 7, 29, 59);
        do_pause();

        // 12 h display view.
        count_down = 1'b0;
        mode_12h = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_time(hrs[i], 0, 0);
            chk($sformatf("disp12_%0d", hrs[i]), disp_hour, dhr[i]);
            chk($sformatf("pm12_%0d", hrs[i]), pm, pmv[i]);
        end

        // Rejected alarm write.
        al_hour = 5'd24; al_min = 6'd0;
        alarm_wr = 1'b1; cycle(); alarm_wr = 1'b0;
        chk("al24_err", load_err, 1);

        // Clear coinciding with a tick.
        load_time(5, 6, 7);
        do_start();
        while (m_pc != TD - 1) cycle();
        btn_clear = 1'b1; cycle(); btn_clear = 1'b0;
        expect_time("clr_tick_time", 0, 0, 0);
        chk("clr_tick_pulse", sec_pulse, 0);

        // Start and pause together.
        btn_start = 1'b1; btn_pause = 1'b1; cycle(); btn_start = 1'b0; btn_pause = 1'b0;
        chk("start_pause", running, 0);

        // Asynchronous reset mid-count, sampled between clock edges.
        load_time(5, 6, 7);
        do_start();
        run(6);
        mode_12h = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #2;
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            btn_start  = ($urandom_range(0, 99) < 6);
            btn_pause  = ($urandom_range(0, 99) < 2);
            btn_clear  = ($urandom_range(0, 99) < 1);
            load       = ($urandom_range(0, 99) < 3);
            alarm_wr   = ($urandom_range(0, 99) < 2);
            tick_in    = 1'($urandom);
            mode_12h   = 1'($urandom);
            if ($urandom_range(0, 99) < 2) count_down = ~count_down;
            if ($urandom_range(0, 99) < 2) alarm_en = ~alarm_en;
            ld_hour = 5'($urandom_range(0, 25));
            ld_min  = 6'($urandom_range(0, 61));
            ld_sec  = 6'($urandom_range(0, 61));
            al_hour = 5'($urandom_range(0, 25));
            al_min  = 6'($urandom_range(0, 61));
            cycle();
        end
        btn_start = 1'b0; btn_pause = 1'b0; btn_clear = 1'b0; load = 1'b0; alarm_wr = 1'b0;
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
